icm_ltc_rx: RTL

Serial receiver for the ICM LTC stamp carried on ICM_GPIO_0. It deserializes 48-bit LTC frames from the ICM and presents the last good value with a validity flag. It sits directly upstream of the time-transfer block, which samples `ltc_out`/`valid_out` on each ICM sync pulse. It also reports framing errors and stuck-low line faults.

---
 rtl/icm_ltc_pkg.sv | 18 +
 rtl/sync.sv | 21 ++
 rtl/icm_ltc_rx.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/icm_ltc_pkg.sv
// Shared types and frame constants for the ICM LTC stamp receiver.
package icm_ltc_pkg;

  localparam int LTC_W = 48;

  // Frame layout: start bit, LTC_W data bits MSB-first, stop bit.
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_ARMED     = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_STOP      = 3'd4
  } state_t;

endpackage

// File: rtl/sync.sv
// Two-flop synchronizer for a single asynchronous bit; reset value selectable
// so an idle-high line does not look active while coming out of reset.
module sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_ff;

  always_ff @(posedge clk) begin
    if (rst) r_ff <= {2{RST_VAL}};
    else     r_ff <= {r_ff[0], i_d};
  end

  assign o_q = r_ff[1];

endmodule

// File: rtl/icm_ltc_rx.sv
// Deserializes 48-bit LTC frames from ICM_GPIO_0 and holds the last good value
// with a freshness flag, plus framing-error and stuck-low line reporting.
module icm_ltc_rx
  import icm_ltc_pkg::*;
#(
  parameter int          SHIFT_CNT     = 20,
  parameter int          IDLE_CNT      = 4000,
  parameter int          STOP_ERR_CNT  = 200,
  parameter logic [31:0] VALID_TIMEOUT = 32'd240_000_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             ser_in,
  output logic [LTC_W-1:0] ltc_out,
  output logic             valid_out,
  output logic             frame_err,
  output logic             line_stuck
);

  localparam int TW = $clog2(SHIFT_CNT);
  localparam int IW = $clog2(IDLE_CNT);
  localparam int LW = $clog2(STOP_ERR_CNT);
  localparam int BW = $clog2(LTC_W + 1);

  localparam logic [TW-1:0] TMR_HALF = TW'(SHIFT_CNT / 2 - 1);
  localparam logic [TW-1:0] TMR_END  = TW'(SHIFT_CNT - 1);
  localparam logic [IW-1:0] IDLE_END = IW'(IDLE_CNT - 1);
  localparam logic [LW-1:0] LOW_END  = LW'(STOP_ERR_CNT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(LTC_W - 1);
  localparam logic [31:0]   TO_END   = VALID_TIMEOUT - 32'd1;

  // NOTE: en low is folded into the synchronous reset so a mid-frame disable
  // discards the frame and forces a fresh full idle qualification.
  logic w_rst;
  logic w_s;

  state_t r_state, w_next_state;

  logic [TW-1:0]    r_timer;
  logic [IW-1:0]    r_idle_cnt;
  logic [LW-1:0]    r_low_cnt;
  logic [BW-1:0]    r_bit_cnt;
  logic [LTC_W-1:0] r_sr;
  logic [LTC_W-1:0] r_ltc;
  logic             r_valid;
  logic [31:0]      r_to_cnt;
  logic             r_frame_err;
  logic             r_line_stuck;

  logic w_tmr_half, w_tmr_end, w_idle_hit, w_timeout;
  logic w_timing, w_shift, w_stop_ok, w_stop_bad, w_stuck_hit;

  assign w_rst = rst | ~en;

  sync #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (w_rst),
    .i_d (ser_in),
    .o_q (w_s)
  );

  assign w_tmr_half = (r_timer == TMR_HALF);
  assign w_tmr_end  = (r_timer == TMR_END);
  assign w_idle_hit = (r_state == S_WAIT_IDLE) && w_s && (r_idle_cnt == IDLE_END);
  assign w_timeout  = r_valid && (r_to_cnt == TO_END);

  always_ff @(posedge clk) begin
    if (w_rst) r_state <= S_WAIT_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_WAIT_IDLE: if (w_idle_hit) w_next_state = S_ARMED;
      S_ARMED:     if (w_s == START_BIT) w_next_state = S_START;
      S_START:     if (w_tmr_half) w_next_state = (w_s == START_BIT) ? S_DATA : S_ARMED;
      S_DATA:      if (w_tmr_end && (r_bit_cnt == BIT_LAST)) w_next_state = S_STOP;
      S_STOP:      if (w_tmr_end) w_next_state = S_WAIT_IDLE;
      default:     w_next_state = S_WAIT_IDLE;
    endcase
  end

  // NOTE: every strobe gets a default first so this block never infers a latch.
  always_comb begin
    w_timing    = 1'b0;
    w_shift     = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    w_stuck_hit = 1'b0;
    case (r_state)
      S_WAIT_IDLE: w_stuck_hit = !w_s && (r_low_cnt == LOW_END);
      S_START:     w_timing = 1'b1;
      S_DATA: begin
        w_timing = 1'b1;
        w_shift  = w_tmr_end;
      end
      S_STOP: begin
        w_timing   = 1'b1;
        w_stop_ok  = w_tmr_end && (w_s == STOP_BIT);
        w_stop_bad = w_tmr_end && (w_s != STOP_BIT);
      end
      default: ;
    endcase
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_timer      <= '0;
      r_idle_cnt   <= '0;
      r_low_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_sr         <= '0;
      r_ltc        <= '0;
      r_valid      <= 1'b0;
      r_to_cnt     <= '0;
      r_frame_err  <= 1'b0;
      r_line_stuck <= 1'b0;
    end else begin
      if (w_timing && !w_shift && (w_next_state == r_state)) r_timer <= r_timer + 1'b1;
      else                                                   r_timer <= '0;

      if ((r_state == S_WAIT_IDLE) && w_s && !w_idle_hit) r_idle_cnt <= r_idle_cnt + 1'b1;
      else                                                r_idle_cnt <= '0;

      if ((r_state == S_WAIT_IDLE) && !w_s)
        r_low_cnt <= (r_low_cnt == LOW_END) ? r_low_cnt : r_low_cnt + 1'b1;
      else
        r_low_cnt <= '0;

      if (r_state != S_DATA) r_bit_cnt <= '0;
      else if (w_shift)      r_bit_cnt <= r_bit_cnt + 1'b1;

      // Shifting happens in r_sr only; ltc_out moves solely on a good stop bit.
      if (w_shift)   r_sr  <= {r_sr[LTC_W-2:0], w_s};
      if (w_stop_ok) r_ltc <= r_sr;

      if (w_stop_ok)                               r_valid <= 1'b1;
      else if (w_stop_bad || w_stuck_hit || w_timeout) r_valid <= 1'b0;

      if (w_stop_ok || !r_valid || w_timeout) r_to_cnt <= '0;
      else                                    r_to_cnt <= r_to_cnt + 32'd1;

      r_frame_err <= w_stop_bad;

      if (w_stuck_hit)     r_line_stuck <= 1'b1;
      else if (w_idle_hit) r_line_stuck <= 1'b0;
    end
  end

  assign ltc_out    = r_ltc;
  assign valid_out  = r_valid;
  assign frame_err  = r_frame_err;
  assign line_stuck = r_line_stuck;

endmodule
